// File: rtl/mp_op_scheduler.sv
// Round-robin front end sharing one iterative add/sub engine between requesters.
// Captures a winner, starts the engine, returns its result, aborts on a hung engine.
module mp_op_scheduler #(
    parameter int OPERAND_WIDTH = 512,
    parameter int N_REQ         = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                           iClk,
    input  logic                           iRstn,
    input  logic [N_REQ-1:0]               iReq,
    input  logic [N_REQ-1:0]               iSub,
    input  logic [N_REQ*OPERAND_WIDTH-1:0] iOpA,
    input  logic [N_REQ*OPERAND_WIDTH-1:0] iOpB,
    output logic [N_REQ-1:0]               oAck,
    output logic [N_REQ-1:0]               oDone,
    output logic                           oErr,
    output logic [OPERAND_WIDTH-1:0]       oRes,
    output logic                           oBusy,
    output logic                           oEngStart,
    output logic                           oEngSub,
    output logic [OPERAND_WIDTH-1:0]       oEngOpA,
    output logic [OPERAND_WIDTH-1:0]       oEngOpB,
    output logic                           oEngRst,
    input  logic [OPERAND_WIDTH-1:0]       iEngRes,
    input  logic                           iEngDone
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ABORT
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [PW-1:0]            grant_q, grant_d;
    logic [TW-1:0]            timer_q, timer_d;
    logic                     sub_q, sub_d;
    logic [OPERAND_WIDTH-1:0] opa_q, opa_d;
    logic [OPERAND_WIDTH-1:0] opb_q, opb_d;
    logic [OPERAND_WIDTH-1:0] res_q, res_d;
    logic [N_REQ-1:0]         ack_q, ack_d;
    logic [N_REQ-1:0]         done_q, done_d;
    logic                     err_q, err_d;
    logic                     start_q, start_d;
    logic                     busy_q, busy_d;
    logic                     eng_rst_q, eng_rst_d;

    logic [PW-1:0]            win;
    logic                     found;
    logic [PW:0]              idx;

    // First requesting index at or above the pointer, wrapping mod N_REQ.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) begin
                idx = idx - (PW+1)'(N_REQ);
            end
            if (!found && iReq[idx[PW-1:0]]) begin
                win   = idx[PW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        timer_d = timer_q;
        sub_d   = sub_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = win;
                    sub_d   = iSub[win];
                    opa_d   = iOpA[int'(win)*OPERAND_WIDTH +: OPERAND_WIDTH];
                    opb_d   = iOpB[int'(win)*OPERAND_WIDTH +: OPERAND_WIDTH];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ptr_d   = (grant_q == PW'(N_REQ-1)) ? '0 : grant_q + 1'b1;
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iEngDone) begin
                    res_d   = iEngRes;
                    state_d = S_RESP;
                end else if (timer_q == TW'(TIMEOUT-1)) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP, S_ABORT: state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        ack_d = '0;
        if (state_d == S_ISSUE) begin
            ack_d[grant_d] = 1'b1;
        end
        done_d = '0;
        if (state_d == S_RESP || state_d == S_ABORT) begin
            done_d[grant_d] = 1'b1;
        end
        err_d     = (state_d == S_ABORT);
        eng_rst_d = (state_d == S_ABORT);
        start_d   = (state_d == S_ISSUE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            timer_q   <= '0;
            sub_q     <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            eng_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            timer_q   <= timer_d;
            sub_q     <= sub_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            res_q     <= res_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            eng_rst_q <= eng_rst_d;
        end
    end

    assign oAck      = ack_q;
    assign oDone     = done_q;
    assign oErr      = err_q;
    assign oRes      = res_q;
    assign oBusy     = busy_q;
    assign oEngStart = start_q;
    assign oEngSub   = sub_q;
    assign oEngOpA   = opa_q;
    assign oEngOpB   = opb_q;
    assign oEngRst   = eng_rst_q;

endmodule
